// File: rtl/hazard_pkg.sv
// Shared encodings and defaults for the stall/flush controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_BUB   = 2'd1,
      MEM_WAIT = 2'd2,
      FLUSH    = 2'd3
   } hz_state_t;

   localparam int REG_W           = 3;
   localparam int DEF_MEM_TIMEOUT = 64;
   localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush controller for hazards bypassing cannot resolve: load-use,
// taken-branch flush and data-cache busy, with a flush deferred across cache waits.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] read_reg1_IF_ID,
   input  logic [REG_W-1:0] read_reg2_IF_ID,
   input  logic             rs_used_IF_ID,
   input  logic             rt_used_IF_ID,
   input  logic             is_store_IF_ID,
   input  logic [REG_W-1:0] w1_reg_ID_EX,
   input  logic             reg_en_ID_EX,
   input  logic             mem_en_ID_EX,
   input  logic             mem_wr_ID_EX,
   input  logic             branch_taken_EX,
   input  logic             dmem_stall,
   input  logic             dmem_done,
   output logic             pc_wr_en,
   output logic             if_id_wr_en,
   output logic             id_ex_wr_en,
   output logic             ex_mem_wr_en,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_bubble,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [1:0]       hz_state
);

   localparam int                WAIT_W = $clog2(MEM_TIMEOUT) + 1;
   // mem_err is set on the edge where wait_cnt becomes MEM_TIMEOUT-1
   localparam logic [WAIT_W-1:0] ERR_AT = WAIT_W'(MEM_TIMEOUT - 2);

   hz_state_t         state, nxt;
   logic              br_pend, br_nxt;
   logic              wait_inc;
   logic              load_use;
   logic [WAIT_W-1:0] wait_cnt;

   // A store-data dependency on rt is covered by the LD->ST bypass
   assign load_use = mem_en_ID_EX & ~mem_wr_ID_EX & reg_en_ID_EX &
                     ((rs_used_IF_ID & (w1_reg_ID_EX == read_reg1_IF_ID)) |
                      (rt_used_IF_ID & (w1_reg_ID_EX == read_reg2_IF_ID) & ~is_store_IF_ID));

   always_comb begin
      pc_wr_en      = 1'b1;
      if_id_wr_en   = 1'b1;
      id_ex_wr_en   = 1'b1;
      ex_mem_wr_en  = 1'b1;
      id_ex_bubble  = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      mem_wb_bubble = 1'b0;
      wait_inc      = 1'b0;
      br_nxt        = br_pend;
      nxt           = RUN;
      if (rst) begin
         pc_wr_en     = 1'b0;
         if_id_wr_en  = 1'b0;
         id_ex_wr_en  = 1'b0;
         ex_mem_wr_en = 1'b0;
         br_nxt       = 1'b0;
      end else if (state == MEM_WAIT && dmem_done) begin
         br_nxt = 1'b0;
         if (br_pend || branch_taken_EX) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            nxt         = FLUSH;
         end
      end else if (state == MEM_WAIT || dmem_stall) begin
         pc_wr_en      = 1'b0;
         if_id_wr_en   = 1'b0;
         id_ex_wr_en   = 1'b0;
         ex_mem_wr_en  = 1'b0;
         mem_wb_bubble = 1'b1;
         wait_inc      = 1'b1;
         br_nxt        = (state == MEM_WAIT) ? (br_pend | branch_taken_EX) : branch_taken_EX;
         nxt           = MEM_WAIT;
      end else if (branch_taken_EX) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         nxt         = FLUSH;
      end else if (load_use && state == RUN) begin
         pc_wr_en     = 1'b0;
         if_id_wr_en  = 1'b0;
         id_ex_bubble = 1'b1;
         nxt          = LU_BUB;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RUN;
         br_pend <= 1'b0;
         mem_err <= 1'b0;
      end else begin
         state   <= nxt;
         br_pend <= br_nxt;
         if (wait_inc && (wait_cnt >= ERR_AT))
            mem_err <= 1'b1;
      end
   end

   assign hz_state = state;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (~pc_wr_en),
      .clr (1'b0),
      .cnt (stall_cnt)
   );

   sat_counter #(.W(WAIT_W)) u_wait_cnt (
      .clk (clk),
      .rst (rst),
      .inc (wait_inc),
      .clr (~wait_inc),
      .cnt (wait_cnt)
   );

endmodule
